// File: rtl/segway_pkg.sv
// Shared widths, constants and small helpers for the segway motor-drive blocks.
package segway_pkg;

    localparam int PWM_W  = 11;
    localparam int SPD_W  = 12;
    localparam int DEAD_W = 6;
    localparam int OVR_W  = 8;

    localparam logic [PWM_W-1:0] DUTY_ZERO = 11'h400;
    localparam logic [PWM_W-1:0] CNT_MAX   = 11'h7FF;

    // Offset-binary duty from the upper speed bits (speed LSB is dropped).
    function automatic logic [PWM_W-1:0] spd_to_duty(input logic [SPD_W-2:0] spd_hi);
        return {~spd_hi[SPD_W-2], spd_hi[SPD_W-3:0]};
    endfunction

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/mtr_drv_nonoverlap.sv
// Dead-time inserter for one half bridge: both drives low for DEAD_TIME clocks
// after every pwm_sig edge, then high side follows pwm_sig and low side its inverse.
module nonoverlap
    import segway_pkg::*;
#(
    parameter logic [DEAD_W-1:0] DEAD_TIME = 6'd32
)(
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_sig,
    input  logic kill,
    output logic PWM1,
    output logic PWM2
);

    logic              prev_r;
    logic [DEAD_W-1:0] dead_r;
    logic              pwm1_r;
    logic              pwm2_r;

    // Edge detect, dead-time count and drive registers; an edge restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
            dead_r <= 6'd0;
            pwm1_r <= 1'b0;
            pwm2_r <= 1'b0;
        end else begin
            prev_r <= pwm_sig;
            if (kill) begin
                dead_r <= 6'd0;
                pwm1_r <= 1'b0;
                pwm2_r <= 1'b0;
            end else if (pwm_sig != prev_r) begin
                dead_r <= 6'd1;
                pwm1_r <= 1'b0;
                pwm2_r <= 1'b0;
            end else if (dead_r != DEAD_TIME) begin
                dead_r <= dead_r + 6'd1;
                pwm1_r <= 1'b0;
                pwm2_r <= 1'b0;
            end else begin
                dead_r <= dead_r;
                pwm1_r <= pwm_sig;
                pwm2_r <= ~pwm_sig;
            end
        end
    end

    assign PWM1 = pwm1_r;
    assign PWM2 = pwm2_r;

endmodule

// File: rtl/mtr_drv.sv
// Two-channel PWM motor driver with dead-time and optional over-current shutdown.
// Define OVR_I_SHUTDOWN_EN to enable the blanked over-current counter and latch.
module mtr_drv
    import segway_pkg::*;
#(
    parameter logic [DEAD_W-1:0] DEAD_TIME   = 6'd32,
    parameter logic [PWM_W-1:0]  BLANK_START = 11'd128,
    parameter logic [PWM_W-1:0]  BLANK_END   = 11'd1023,
    parameter logic [OVR_W-1:0]  OVR_I_LIMIT = 8'd10
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [SPD_W-1:0] lft_spd,
    input  logic signed [SPD_W-1:0] rght_spd,
    input  logic                    OVR_I_lft,
    input  logic                    OVR_I_rght,
    output logic                    PWM1_lft,
    output logic                    PWM2_lft,
    output logic                    PWM1_rght,
    output logic                    PWM2_rght,
    output logic                    PWM_synch,
    output logic                    OVR_I_shtdwn
);

    logic [PWM_W-1:0] cnt_r;
    logic [PWM_W-1:0] duty_lft_r;
    logic [PWM_W-1:0] duty_rght_r;
    logic             pwm_lft_r;
    logic             pwm_rght_r;
    logic             synch_r;
    logic             kill_s;
    logic             unused_s;

    // Period counter, shadow duties (loaded only at period end) and raw PWM compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 11'd0;
            duty_lft_r  <= DUTY_ZERO;
            duty_rght_r <= DUTY_ZERO;
            pwm_lft_r   <= 1'b0;
            pwm_rght_r  <= 1'b0;
            synch_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_r + 11'd1;
            synch_r    <= (cnt_r == CNT_MAX);
            pwm_lft_r  <= (cnt_r < duty_lft_r);
            pwm_rght_r <= (cnt_r < duty_rght_r);
            if (cnt_r == CNT_MAX) begin
                duty_lft_r  <= spd_to_duty(lft_spd[SPD_W-1:1]);
                duty_rght_r <= spd_to_duty(rght_spd[SPD_W-1:1]);
            end else begin
                duty_lft_r  <= duty_lft_r;
                duty_rght_r <= duty_rght_r;
            end
        end
    end

`ifdef OVR_I_SHUTDOWN_EN
    logic             sample_s;
    logic             shtdwn_nxt_s;
    logic             ovr_seen_r;
    logic [OVR_W-1:0] ovr_cnt_r;
    logic             shtdwn_r;

    // Blanked over-current sample and next shutdown state (shared with the bridge kill).
    always_comb begin
        sample_s     = (OVR_I_lft | OVR_I_rght) &&
                       (cnt_r >= BLANK_START) && (cnt_r <= BLANK_END);
        shtdwn_nxt_s = shtdwn_r | (ovr_cnt_r >= OVR_I_LIMIT);
    end

    // Per-period over-current flag, consecutive-period counter and shutdown latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_seen_r <= 1'b0;
            ovr_cnt_r  <= 8'd0;
            shtdwn_r   <= 1'b0;
        end else begin
            shtdwn_r <= shtdwn_nxt_s;
            if (cnt_r == CNT_MAX) begin
                ovr_seen_r <= 1'b0;
                if (ovr_seen_r | sample_s) begin
                    ovr_cnt_r <= sat_inc(ovr_cnt_r);
                end else begin
                    ovr_cnt_r <= 8'd0;
                end
            end else begin
                ovr_seen_r <= ovr_seen_r | sample_s;
                ovr_cnt_r  <= ovr_cnt_r;
            end
        end
    end

    assign kill_s       = shtdwn_nxt_s;
    assign OVR_I_shtdwn = shtdwn_r;
    assign unused_s     = lft_spd[0] ^ rght_spd[0];
`else
    assign kill_s       = 1'b0;
    assign OVR_I_shtdwn = 1'b0;
    assign unused_s     = ^{lft_spd[0], rght_spd[0], OVR_I_lft, OVR_I_rght,
                            BLANK_START, BLANK_END, OVR_I_LIMIT};
`endif

    nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_nonoverlap_lft (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_sig (pwm_lft_r),
        .kill    (kill_s),
        .PWM1    (PWM1_lft),
        .PWM2    (PWM2_lft)
    );

    nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_nonoverlap_rght (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_sig (pwm_rght_r),
        .kill    (kill_s),
        .PWM1    (PWM1_rght),
        .PWM2    (PWM2_rght)
    );

    assign PWM_synch = synch_r;

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: time-based reference model of the PWM waveform,
// dead-time windows and over-current periods, compared every clock.
module tb_mtr_drv;

    localparam int D   = 32;
    localparam int PER = 2048;
    localparam int LIM = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic signed [11:0] lft_spd = 12'sd0;
    logic signed [11:0] rght_spd = 12'sd0;
    logic              OVR_I_lft = 1'b0;
    logic              OVR_I_rght = 1'b0;
    logic              PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, PWM_synch, OVR_I_shtdwn;

    mtr_drv dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .OVR_I_lft    (OVR_I_lft),
        .OVR_I_rght   (OVR_I_rght),
        .PWM1_lft     (PWM1_lft),
        .PWM2_lft     (PWM2_lft),
        .PWM1_rght    (PWM1_rght),
        .PWM2_rght    (PWM2_rght),
        .PWM_synch    (PWM_synch),
        .OVR_I_shtdwn (OVR_I_shtdwn)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: clocks since reset, latched duties, recent pwm_sig history.
    int         m_t;
    int         duty_l, duty_r;
    bit         hl[$];
    bit         hr[$];
    int         consec;
    bit         ovr_bad;
    bit         sd;
    logic [5:0] exp_vec;

    function automatic bit all_is(input bit q[$], input bit v);
        if (q.size() != D + 1) return 1'b0;
        foreach (q[i]) if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [5:0] obs();
        return {PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, PWM_synch, OVR_I_shtdwn};
    endfunction

    task automatic model_reset();
        m_t = 0; duty_l = 1024; duty_r = 1024;
        hl.delete(); hl.push_back(1'b0);
        hr.delete(); hr.push_back(1'b0);
        consec = 0; ovr_bad = 1'b0; sd = 1'b0;
    endtask

    // Advance one clock: waveform value is (cnt < duty); a drive is on only after
    // its level has held for D+1 consecutive samples.
    task automatic step();
        int c;
        bit sl, sr;
        @(posedge clk);
        c = m_t % PER;
`ifdef OVR_I_SHUTDOWN_EN
        if (consec >= LIM) sd = 1'b1;
        if (c >= 128 && c <= 1023 && (OVR_I_lft || OVR_I_rght)) ovr_bad = 1'b1;
        if (c == PER - 1) begin
            consec  = ovr_bad ? ((consec < 255) ? consec + 1 : 255) : 0;
            ovr_bad = 1'b0;
        end
`endif
        sl = (c < duty_l);
        sr = (c < duty_r);
        exp_vec = {!sd && all_is(hl, 1'b1), !sd && all_is(hl, 1'b0),
                   !sd && all_is(hr, 1'b1), !sd && all_is(hr, 1'b0),
                   (c == PER - 1), sd};
        if (c == PER - 1) begin
            duty_l = (int'(lft_spd) + 2048) / 2;
            duty_r = (int'(rght_spd) + 2048) / 2;
        end
        hl.push_back(sl); if (hl.size() > D + 1) void'(hl.pop_front());
        hr.push_back(sr); if (hr.size() > D + 1) void'(hr.pop_front());
        m_t++;
        #1;
    endtask

    task automatic test_reset();
        lft_spd = 12'sd0; rght_spd = 12'sd0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== 6'b0) begin bad++; $display("FAIL reset_state got=%b exp=%b", obs(), 6'b0); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL reset_startup t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
        end
    endtask

    task automatic test_duty_50();
        int n1, n2;
        lft_spd  = 12'sd0;
        rght_spd = 12'($urandom_range(0, 4095));
        n1 = 0; n2 = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            if (i >= PER && (m_t % PER) == 0) break;
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL duty50_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
        end
        for (int i = 0; i < PER; i++) begin
            step();
            n1 += int'(PWM1_lft); n2 += int'(PWM2_lft);
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL duty50_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
        end
        total++;
        if (n1 !== 1024 - D) begin bad++; $display("FAIL duty50_pwm1_count got=%0d exp=%0d", n1, 1024 - D); end
        total++;
        if (n2 !== 1024 - D) begin bad++; $display("FAIL duty50_pwm2_count got=%0d exp=%0d", n2, 1024 - D); end
    endtask

    task automatic test_extremes();
        int n1, n2;
        int spd_tab[2] = '{2047, -2048};
        int e1_tab[2]  = '{2047 - D, 0};
        int e2_tab[2]  = '{0, PER};
        for (int k = 0; k < 2; k++) begin
            rght_spd = 12'(spd_tab[k]);
            lft_spd  = 12'($urandom_range(0, 4095));
            n1 = 0; n2 = 0;
            while ((m_t % PER) != 0 || n1 == 0) begin
                step();
                n1 = 1;
                total++;
                if (obs() !== exp_vec) begin bad++; $display("FAIL extreme_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
            end
            n1 = 0;
            for (int i = 0; i < 2 * PER; i++) begin
                step();
                if (i >= PER) begin n1 += int'(PWM1_rght); n2 += int'(PWM2_rght); end
                total++;
                if (obs() !== exp_vec) begin bad++; $display("FAIL extreme_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
            end
            total++;
            if (n1 !== e1_tab[k]) begin bad++; $display("FAIL extreme_pwm1 spd=%0d got=%0d exp=%0d", spd_tab[k], n1, e1_tab[k]); end
            total++;
            if (n2 !== e2_tab[k]) begin bad++; $display("FAIL extreme_pwm2 spd=%0d got=%0d exp=%0d", spd_tab[k], n2, e2_tab[k]); end
        end
    endtask

    task automatic test_mid_change();
        int n1, n2;
        lft_spd = 12'sd0;
        n1 = 0; n2 = 0;
        for (int i = 0; i < PER; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL midchg_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
            if ((m_t % PER) == 0) break;
        end
        for (int i = 0; i < 2 * PER; i++) begin
            step();
            if ((m_t % PER) == 500 && i < PER) lft_spd = 12'sd1000;
            if (i < PER) n1 += int'(PWM1_lft); else n2 += int'(PWM1_lft);
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL midchg_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
        end
        total++;
        if (n1 !== 1024 - D) begin bad++; $display("FAIL midchg_same_period got=%0d exp=%0d", n1, 1024 - D); end
        total++;
        if (n2 !== 1524 - D) begin bad++; $display("FAIL midchg_next_period got=%0d exp=%0d", n2, 1524 - D); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * PER; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL random_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
            total++;
            if (((PWM1_lft & PWM2_lft) | (PWM1_rght & PWM2_rght)) !== 1'b0) begin
                bad++; $display("FAIL random_overlap t=%0d got=1 exp=0", m_t);
            end
            if ($urandom_range(0, 255) == 0) lft_spd  = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 255) == 0) rght_spd = 12'($urandom_range(0, 4095));
        end
    endtask

    task automatic test_synch_period();
        int last, seen;
        last = -1; seen = 0;
        for (int i = 0; i < 3 * PER + 10; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL synch_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
            if (PWM_synch === 1'b1) begin
                if (last >= 0) begin
                    total++;
                    if (m_t - last !== PER) begin bad++; $display("FAIL synch_interval got=%0d exp=%0d", m_t - last, PER); end
                end
                last = m_t; seen++;
            end
        end
        total++;
        if (seen !== 3) begin bad++; $display("FAIL synch_count got=%0d exp=3", seen); end
    endtask

    task automatic test_ovr();
        int nper;
`ifdef OVR_I_SHUTDOWN_EN
        nper = 19;
`else
        nper = 3;
`endif
        while ((m_t % PER) != 0) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL ovr_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
        end
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < PER; i++) begin
                step();
                total++;
                if (obs() !== exp_vec) begin bad++; $display("FAIL ovr_wave p=%0d t=%0d got=%b exp=%b", p, m_t, obs(), exp_vec); end
                OVR_I_lft  = ((m_t % PER) == 200) && (p != 8);
                OVR_I_rght = ((m_t % PER) >= 50 && (m_t % PER) < 60) || ((m_t % PER) == 1500);
            end
        end
        OVR_I_lft = 1'b0; OVR_I_rght = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL ovr_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
        end
`ifdef OVR_I_SHUTDOWN_EN
        total++;
        if (OVR_I_shtdwn !== 1'b1) begin bad++; $display("FAIL ovr_shtdwn got=%b exp=1", OVR_I_shtdwn); end
        total++;
        if ({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght} !== 4'b0) begin
            bad++; $display("FAIL ovr_pwm_off got=%b exp=0000", {PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght});
        end
`else
        total++;
        if (OVR_I_shtdwn !== 1'b0) begin bad++; $display("FAIL ovr_ignored got=%b exp=0", OVR_I_shtdwn); end
`endif
    endtask

    task automatic test_reset_mid();
        int first;
        lft_spd = 12'sd0;
        for (int i = 0; i < PER; i++) begin
            if ((m_t % PER) == 700) break;
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== 6'b0) begin bad++; $display("FAIL reset_mid_immediate got=%b exp=%b", obs(), 6'b0); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        first = -1;
        for (int i = 0; i < PER + 20; i++) begin
            step();
            total++;
            if (obs() !== exp_vec) begin bad++; $display("FAIL reset_mid_wave t=%0d got=%b exp=%b", m_t, obs(), exp_vec); end
            if (PWM_synch === 1'b1 && first < 0) first = m_t;
        end
        total++;
        if (first !== PER) begin bad++; $display("FAIL reset_mid_first_synch got=%0d exp=%0d", first, PER); end
    endtask

    initial begin
        test_reset();
        test_duty_50();
        test_extremes();
        test_mid_change();
        test_random();
        test_synch_period();
        test_ovr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mtr_drv.md
MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 Parameter DEAD_TIME, default 6'd32: non-overlap interval in clocks; legal range 1-63.
REQ-002 Parameter BLANK_START, default 11'd128: first PWM count at which over-current is sampled.
REQ-003 Parameter BLANK_END, default 11'd1023: last PWM count at which over-current is sampled.
REQ-004 Parameter OVR_I_LIMIT, default 8'd10: consecutive over-current periods before shutdown.
REQ-005 Port clk  in  1: single system clock; all logic rising-edge.
REQ-006 Port rst_n  in  1: asynchronous active-low reset.
REQ-007 Port lft_spd  in  12 signed: left wheel speed command, -2048..2047.
REQ-008 Port rght_spd  in  12 signed: right wheel speed command.
REQ-009 Port OVR_I_lft / OVR_I_rght  in  1 each: motor over-current flags, synchronous to clk.
REQ-010 Port PWM1_lft / PWM2_lft  out  1 each: left bridge high-side / low-side drives.
REQ-011 Port PWM1_rght / PWM2_rght  out  1 each: right bridge high-side / low-side drives.
REQ-012 Port PWM_synch  out  1: one-clock pulse at PWM period start, for A2D sampling.
REQ-013 Port OVR_I_shtdwn  out  1: latched over-current shutdown flag.

Function
REQ-014 Free-running 11-bit counter cnt SHALL increment every clock and wrap 2047->0 (period 2048 clocks).
REQ-015 Duty SHALL be offset-binary: duty = {~spd[11], spd[10:1]}, 11 bits; spd 0 -> 0x400 (50%).
REQ-016 Speed inputs SHALL be latched into shadow duty registers only on the clock where cnt==2047; mid-period changes are ignored.
REQ-017 Internal registered pwm_sig SHALL equal (cnt < duty_shadow), one clock after cnt; duty 0 gives constant low.
REQ-018 Any pwm_sig edge SHALL force PWM1 and PWM2 low on the next clock.
REQ-019 After pwm_sig is stable for DEAD_TIME clocks: PWM1 = pwm_sig, PWM2 = ~pwm_sig.
REQ-020 PWM1 and PWM2 of one side SHALL never be high simultaneously.
REQ-021 An edge arriving during a dead-time interval SHALL restart that interval.
REQ-022 PWM_synch SHALL be a registered decode of cnt==2047, high exactly one clock per period (aligned with cnt==0).
REQ-023 A period is over-current when OVR_I_lft or OVR_I_rght is high on any clock with BLANK_START <= cnt <= BLANK_END.
REQ-024 Consecutive over-current periods are counted in an 8-bit saturating counter, evaluated at cnt==2047.
REQ-025 A clean period SHALL clear the counter.
REQ-026 When the count reaches OVR_I_LIMIT, OVR_I_shtdwn SHALL set on the next clock.
REQ-027 While OVR_I_shtdwn is high, all four PWM outputs are forced low; only reset clears it.

Reset
REQ-028 Reset SHALL force, immediately and asynchronously:
- cnt=0, duty_shadow=0x400, pwm_sig=0
- dead-time counters=0, over-current counter=0
- all PWM outputs=0, PWM_synch=0, OVR_I_shtdwn=0
REQ-029 Reset mid-period SHALL restart from cnt=0; the first dead time completes before any drive goes high.

Configuration
REQ-030 Macro OVR_I_SHUTDOWN_EN:
- defined: REQ-023..027 active.
- undefined: over-current inputs ignored, OVR_I_shtdwn tied 0, counter logic absent.

Structure
REQ-031 Shared package segway_pkg SHALL hold PWM_W=11, SPD_W=12 and DUTY_ZERO=11'h400.
REQ-032 One sub-module, nonoverlap (pwm_sig in, PWM1/PWM2 out, DEAD_TIME parameter), instantiated once per side.

Verification
REQ-033 lft_spd=0 -> PWM1_lft high 1024-DEAD_TIME clocks per 2048-clock period; PWM2_lft complementary with dead gaps.
REQ-034 rght_spd=2047 -> duty 0x7FF; rght_spd=-2048 -> duty 0, PWM1_rght constant low, PWM2_rght constant high.
REQ-035 Change lft_spd 0->1000 at cnt=500 -> duty 0x5F4 first applies in the next period.
REQ-036 Every clock checks PWM1&PWM2==0 per side; PWM_synch period is exactly 2048 clocks.
REQ-037 OVR_I_lft high at cnt=200 for 10 consecutive periods -> OVR_I_shtdwn set, all PWM low; a clean 9th period prevents shutdown.
REQ-038 rst_n low mid-period -> all outputs low immediately; after release, cnt restarts at 0 and PWM_synch first fires at clock 2048.
